// File: rtl/wb_pkg.sv
// Shared constants and grant payload for the writeback arbiter.
package wb_pkg;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned NUM_SRC = 4;
  localparam int unsigned PTR_W   = 2;
  localparam int unsigned STALL_W = 16;

  localparam logic [PTR_W-1:0] SRC_ALU_A = 2'd0;
  localparam logic [PTR_W-1:0] SRC_ALU_B = 2'd1;
  localparam logic [PTR_W-1:0] SRC_LS_A  = 2'd2;
  localparam logic [PTR_W-1:0] SRC_LS_B  = 2'd3;

  typedef struct packed {
    logic             b_vld;
    logic [PTR_W-1:0] b_idx;
    logic             a_vld;
    logic [PTR_W-1:0] a_idx;
  } grant_t;
endpackage

// File: rtl/wb_arbiter_if.sv
// Producer/register-file bundle for wb_arbiter; slave is the arbiter side.
interface wb_arbiter_if #(
  parameter int unsigned DATA_W  = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W  = wb_pkg::ADDR_W,
  parameter int unsigned NUM_SRC = wb_pkg::NUM_SRC
);
  logic [NUM_SRC-1:0]        srcValid_i;
  logic [NUM_SRC*ADDR_W-1:0] srcAddr_i;
  logic [NUM_SRC*DATA_W-1:0] srcData_i;
  logic [NUM_SRC-1:0]        srcReady_o;
  logic                      writeEnablePortA_o;
  logic                      writeEnablePortB_o;
  logic [ADDR_W-1:0]         writeAPortAddr_o;
  logic [ADDR_W-1:0]         writeBPortAddr_o;
  logic [DATA_W-1:0]         writeAPortData_o;
  logic [DATA_W-1:0]         writeBPortData_o;
  logic [ADDR_W-1:0]         fwdAddr_i;
  logic                      fwdHit_o;
  logic [DATA_W-1:0]         fwdData_o;
  logic [15:0]               stallCount_o;

  modport master (
    output srcValid_i, srcAddr_i, srcData_i, fwdAddr_i,
    input  srcReady_o, writeEnablePortA_o, writeEnablePortB_o,
           writeAPortAddr_o, writeBPortAddr_o, writeAPortData_o,
           writeBPortData_o, fwdHit_o, fwdData_o, stallCount_o
  );

  modport slave (
    input  srcValid_i, srcAddr_i, srcData_i, fwdAddr_i,
    output srcReady_o, writeEnablePortA_o, writeEnablePortB_o,
           writeAPortAddr_o, writeBPortAddr_o, writeAPortData_o,
           writeBPortData_o, fwdHit_o, fwdData_o, stallCount_o
  );
endinterface

// File: rtl/wb_rr_picker.sv
// Two-grant rotating scan: first valid source from i_ptr goes to port A,
// the next valid one to port B unless it targets the same address.
module wb_rr_picker #(
  parameter int unsigned ADDR_W  = wb_pkg::ADDR_W,
  parameter int unsigned NUM_SRC = wb_pkg::NUM_SRC
) (
  input  logic [NUM_SRC-1:0]        i_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] i_addr,
  input  logic [wb_pkg::PTR_W-1:0]  i_ptr,
  output wb_pkg::grant_t            o_grant
);
  import wb_pkg::*;

  logic [ADDR_W-1:0] w_addr [NUM_SRC];
  logic [PTR_W-1:0]  w_idx;
  logic              w_seen_b;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign w_addr[k] = i_addr[k*ADDR_W +: ADDR_W];
  end

  // Only the second valid candidate may take port B; a same-address
  // candidate is deferred so its write lands after port A's.
  always_comb begin
    o_grant  = '0;
    w_idx    = '0;
    w_seen_b = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      w_idx = i_ptr + PTR_W'(i);
      if (i_valid[w_idx]) begin
        if (!o_grant.a_vld) begin
          o_grant.a_vld = 1'b1;
          o_grant.a_idx = w_idx;
        end else if (!w_seen_b) begin
          w_seen_b = 1'b1;
          if (w_addr[w_idx] != w_addr[o_grant.a_idx]) begin
            o_grant.b_vld = 1'b1;
            o_grant.b_idx = w_idx;
          end
        end
      end
    end
  end
endmodule

// File: rtl/wb_arbiter.sv
// Dual-port register-file writeback arbiter with round-robin fairness.
// Optional forwarding lookup enabled by WB_ARBITER_BYPASS_EN.
module wb_arbiter #(
  parameter int unsigned DATA_W  = wb_pkg::DATA_W,
  parameter int unsigned ADDR_W  = wb_pkg::ADDR_W,
  parameter int unsigned NUM_SRC = wb_pkg::NUM_SRC
) (
  input logic         clock_i,
  input logic         reset_i,
  wb_arbiter_if.slave bus
);
  import wb_pkg::*;

  grant_t             w_grant;
  logic [NUM_SRC-1:0] w_ready;
  logic               w_stall;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [ADDR_W-1:0]  w_addr [NUM_SRC];
  logic [DATA_W-1:0]  w_data [NUM_SRC];

  logic [PTR_W-1:0]   r_ptr;
  logic [STALL_W-1:0] r_stall_cnt;
  logic               r_we_a, r_we_b;
  logic [ADDR_W-1:0]  r_addr_a, r_addr_b;
  logic [DATA_W-1:0]  r_data_a, r_data_b;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign w_addr[k] = bus.srcAddr_i[k*ADDR_W +: ADDR_W];
    assign w_data[k] = bus.srcData_i[k*DATA_W +: DATA_W];
  end

  wb_rr_picker #(.ADDR_W(ADDR_W), .NUM_SRC(NUM_SRC)) u_picker (
    .i_valid (bus.srcValid_i),
    .i_addr  (bus.srcAddr_i),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_ready = '0;
    if (reset_i) begin
      if (w_grant.a_vld) w_ready[w_grant.a_idx] = 1'b1;
      if (w_grant.b_vld) w_ready[w_grant.b_idx] = 1'b1;
    end
  end

  assign w_stall    = |(bus.srcValid_i & ~w_ready);
  assign w_next_ptr = (w_grant.b_vld ? w_grant.b_idx : w_grant.a_idx) + PTR_W'(1);

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      r_ptr       <= '0;
      r_stall_cnt <= '0;
      r_we_a      <= 1'b0;
      r_we_b      <= 1'b0;
      r_addr_a    <= '0;
      r_addr_b    <= '0;
      r_data_a    <= '0;
      r_data_b    <= '0;
    end else begin
      r_we_a   <= w_grant.a_vld;
      r_addr_a <= w_grant.a_vld ? w_addr[w_grant.a_idx] : '0;
      r_data_a <= w_grant.a_vld ? w_data[w_grant.a_idx] : '0;
      r_we_b   <= w_grant.b_vld;
      r_addr_b <= w_grant.b_vld ? w_addr[w_grant.b_idx] : '0;
      r_data_b <= w_grant.b_vld ? w_data[w_grant.b_idx] : '0;
      if (w_grant.a_vld) r_ptr <= w_next_ptr;
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + STALL_W'(1);
    end
  end

  assign bus.srcReady_o         = w_ready;
  assign bus.writeEnablePortA_o = r_we_a;
  assign bus.writeEnablePortB_o = r_we_b;
  assign bus.writeAPortAddr_o   = r_addr_a;
  assign bus.writeBPortAddr_o   = r_addr_b;
  assign bus.writeAPortData_o   = r_data_a;
  assign bus.writeBPortData_o   = r_data_b;
  assign bus.stallCount_o       = r_stall_cnt;

`ifdef WB_ARBITER_BYPASS_EN
  logic              w_fwd_hit;
  logic [DATA_W-1:0] w_fwd_data;

  // Same-address pairs never issue together, so at most one port matches.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (r_we_a && (r_addr_a == bus.fwdAddr_i)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_data_a;
    end else if (r_we_b && (r_addr_b == bus.fwdAddr_i)) begin
      w_fwd_hit  = 1'b1;
      w_fwd_data = r_data_b;
    end
  end

  assign bus.fwdHit_o  = w_fwd_hit;
  assign bus.fwdData_o = w_fwd_data;
`else
  logic w_unused_fwd_addr;
  assign w_unused_fwd_addr = ^bus.fwdAddr_i;
  assign bus.fwdHit_o      = 1'b0;
  assign bus.fwdData_o     = '0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed cases then random traffic
// against a queue-based reference of the grant rules.
module tb_wb_arbiter;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 5;
  localparam int unsigned NS = 4;

  logic clk;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) bus ();

  wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .NUM_SRC(NS)) dut (
    .clock_i (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pending source requests and reference state
  bit p_vld  [NS];
  int p_addr [NS];
  int p_data [NS];
  int fwd_addr;
  int mode;  // 0: granted sources go idle, 1: random refill, 2: keep requesting
  int m_ptr, m_stall;
  bit m_en_a, m_en_b;
  int m_addr_a, m_addr_b, m_data_a, m_data_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic new_request(input int k);
    p_vld[k]  = ($urandom_range(0, 3) != 0);
    p_addr[k] = int'($urandom_range(0, 7));
    p_data[k] = int'($urandom_range(0, 65535));
  endtask

  task automatic step(input bit chk_on);
    int q[$];
    int ga, gb;
    logic [NS-1:0] exp_rdy;
    bit stalled, e_hit;
    int e_fdata;
    for (int k = 0; k < NS; k++) begin
      bus.srcValid_i[k]           = p_vld[k];
      bus.srcAddr_i[k*AW +: AW]   = AW'(p_addr[k]);
      bus.srcData_i[k*DW +: DW]   = DW'(p_data[k]);
    end
    bus.fwdAddr_i = AW'(fwd_addr);
    #3;
    ga = -1; gb = -1; exp_rdy = '0;
    if (rst_n) begin
      for (int off = 0; off < NS; off++)
        if (p_vld[(m_ptr + off) % NS]) q.push_back((m_ptr + off) % NS);
      if (q.size() > 0) ga = q[0];
      if (q.size() > 1 && p_addr[q[1]] != p_addr[q[0]]) gb = q[1];
      if (ga >= 0) exp_rdy[ga] = 1'b1;
      if (gb >= 0) exp_rdy[gb] = 1'b1;
    end
    if (chk_on) chk("ready", bus.srcReady_o, exp_rdy);
    @(posedge clk);
    #1;
    if (!rst_n) begin
      m_ptr = 0; m_stall = 0;
      m_en_a = 0; m_addr_a = 0; m_data_a = 0;
      m_en_b = 0; m_addr_b = 0; m_data_b = 0;
    end else begin
      m_en_a   = (ga >= 0);
      m_addr_a = m_en_a ? p_addr[ga] : 0;
      m_data_a = m_en_a ? p_data[ga] : 0;
      m_en_b   = (gb >= 0);
      m_addr_b = m_en_b ? p_addr[gb] : 0;
      m_data_b = m_en_b ? p_data[gb] : 0;
      stalled = 0;
      for (int k = 0; k < NS; k++) if (p_vld[k] && !exp_rdy[k]) stalled = 1;
      if (stalled && m_stall < 65535) m_stall++;
      if (gb >= 0) m_ptr = (gb + 1) % NS;
      else if (ga >= 0) m_ptr = (ga + 1) % NS;
      if (mode != 2) begin
        if (ga >= 0) p_vld[ga] = 0;
        if (gb >= 0) p_vld[gb] = 0;
      end
      if (mode == 1)
        for (int k = 0; k < NS; k++) if (!p_vld[k]) new_request(k);
    end
    e_hit = 0; e_fdata = 0;
`ifdef WB_ARBITER_BYPASS_EN
    if (m_en_a && m_addr_a == fwd_addr) begin e_hit = 1; e_fdata = m_data_a; end
    else if (m_en_b && m_addr_b == fwd_addr) begin e_hit = 1; e_fdata = m_data_b; end
`endif
    if (chk_on) begin
      chk("we_a",   bus.writeEnablePortA_o, m_en_a);
      chk("addr_a", bus.writeAPortAddr_o, m_addr_a);
      chk("data_a", bus.writeAPortData_o, m_data_a);
      chk("we_b",   bus.writeEnablePortB_o, m_en_b);
      chk("addr_b", bus.writeBPortAddr_o, m_addr_b);
      chk("data_b", bus.writeBPortData_o, m_data_b);
      chk("stall",  bus.stallCount_o, m_stall);
      chk("fwd_hit",  bus.fwdHit_o, e_hit);
      chk("fwd_data", bus.fwdData_o, e_fdata);
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < NS; k++) begin p_vld[k] = 0; p_addr[k] = 0; p_data[k] = 0; end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) step(1);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; mode = 0; fwd_addr = 0;
    m_ptr = 0; m_stall = 0;
    m_en_a = 0; m_en_b = 0; m_addr_a = 0; m_addr_b = 0; m_data_a = 0; m_data_b = 0;
    clear_src();
    @(posedge clk); #1;

    // Reset with every source requesting
    for (int k = 0; k < NS; k++) begin p_vld[k] = 1; p_addr[k] = k + 1; p_data[k] = 16'hA000 + k; end
    do_reset();
    chk("rst_stall", bus.stallCount_o, 0);
    chk("rst_we_a", bus.writeEnablePortA_o, 0);

    // Two sparse sources land on A and B
    clear_src(); do_reset();
    p_vld[0] = 1; p_addr[0] = 3; p_data[0] = 16'h1111;
    p_vld[2] = 1; p_addr[2] = 7; p_data[2] = 16'h2222;
    fwd_addr = 7;
    step(1);
    chk("d32_addr_a", bus.writeAPortAddr_o, 3);
    chk("d32_data_b", bus.writeBPortData_o, 16'h2222);
`ifdef WB_ARBITER_BYPASS_EN
    chk("d36_fwd_data", bus.fwdData_o, 16'h2222);
`else
    chk("d36_fwd_hit", bus.fwdHit_o, 0);
`endif
    // pointer now 3: a lone source 1 request goes to port A
    p_vld[1] = 1; p_addr[1] = 4; p_data[1] = 16'h3333;
    step(1);

    // All four valid, distinct addresses
    clear_src(); do_reset(); fwd_addr = 0;
    for (int k = 0; k < NS; k++) begin p_vld[k] = 1; p_addr[k] = 10 + k; p_data[k] = 16'hB000 + k; end
    step(1);
    step(1);
    chk("d33_data_b", bus.writeBPortData_o, 16'hB003);
    chk("d33_stall", bus.stallCount_o, 1);

    // Same-address pair defers the second writer
    clear_src(); do_reset();
    p_vld[0] = 1; p_addr[0] = 9; p_data[0] = 16'hC000;
    p_vld[1] = 1; p_addr[1] = 9; p_data[1] = 16'hC001;
    step(1);
    chk("d34_we_b_c1", bus.writeEnablePortB_o, 0);
    step(1);
    chk("d34_data_a_c2", bus.writeAPortData_o, 16'hC001);

    // Random traffic with occasional mid-operation reset
    clear_src(); do_reset(); mode = 1;
    for (int k = 0; k < NS; k++) new_request(k);
    for (int n = 0; n < 400; n++) begin
      fwd_addr = int'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 49) != 0);
      step(1);
    end
    rst_n = 1'b1;

    // Stall counter saturation
    mode = 2; clear_src(); do_reset();
    for (int k = 0; k < NS; k++) begin p_vld[k] = 1; p_addr[k] = 20 + k; p_data[k] = 16'hD000 + k; end
    repeat (65533) step(0);
    step(1);
    chk("d35_stall_fffe", bus.stallCount_o, 16'hFFFE);
    repeat (3) step(1);
    chk("d35_stall_ffff", bus.stallCount_o, 16'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
